// File: rtl/coin_input_conditioner_if.sv
// Coin-slot bus between the sensor front end and the vending FSM.
// With COIN_TOTAL_EN defined the bus also carries the running total and its clear.
interface coin_input_conditioner_if;
    logic [2:0] coinRaw;
    logic       fiveKurus;
    logic       tenKurus;
    logic       twentyFiveKurus;
    logic       coinReject;
`ifdef COIN_TOTAL_EN
    logic       clearTotal;
    logic [7:0] totalKurus;

    modport master (
        output coinRaw, clearTotal,
        input  fiveKurus, tenKurus, twentyFiveKurus, coinReject, totalKurus
    );
    modport slave (
        input  coinRaw, clearTotal,
        output fiveKurus, tenKurus, twentyFiveKurus, coinReject, totalKurus
    );
`else
    modport master (
        output coinRaw,
        input  fiveKurus, tenKurus, twentyFiveKurus, coinReject
    );
    modport slave (
        input  coinRaw,
        output fiveKurus, tenKurus, twentyFiveKurus, coinReject
    );
`endif
endinterface

// File: rtl/coin_input_conditioner.sv
// Synchronizes, debounces and arbitrates the three coin sensors into one-hot coin pulses.
// Optional running total in kurus is enabled by defining COIN_TOTAL_EN.
module coin_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable
);
    logic             sync1, sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any agreement with the stable value restarts the count, so glitches never flip it.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module coin_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 3,
    parameter int unsigned HOLDOFF_CYCLES  = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    coin_input_conditioner_if.slave   coinBus
);
    typedef enum logic [1:0] {IDLE, EMIT, HOLDOFF} state_t;

    logic [2:0] stable;
    logic [2:0] stableD;
    logic [2:0] req;
    logic       reqOne;
    logic       reqMulti;
    state_t     state;
    logic [3:0] holdCnt;
    logic [2:0] coinPulse;
    logic       rejectQ;

    for (genvar i = 0; i < 3; i++) begin : g_bit
        logic rawBit;
        logic stableBit;
        assign rawBit    = coinBus.coinRaw[i];
        assign stable[i] = stableBit;
        coin_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clock (clock),
            .reset (reset),
            .raw   (rawBit),
            .stable(stableBit)
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) stableD <= '0;
        else       stableD <= stable;
    end

    // Only debounced presses request; releases are silent.
    assign req      = stable & ~stableD;
    assign reqOne   = (req != 3'b000) && ((req & (req - 3'b001)) == 3'b000);
    assign reqMulti = (req != 3'b000) && !reqOne;

    // coinPulse holds the latched coin and is nonzero only while in EMIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            holdCnt   <= '0;
            coinPulse <= '0;
            rejectQ   <= 1'b0;
        end else begin
            coinPulse <= '0;
            rejectQ   <= 1'b0;
            case (state)
                IDLE: begin
                    if (reqOne) begin
                        coinPulse <= req;
                        state     <= EMIT;
                    end else if (reqMulti) begin
                        rejectQ <= 1'b1;
                        holdCnt <= '0;
                        state   <= HOLDOFF;
                    end
                end
                EMIT: begin
                    holdCnt <= '0;
                    state   <= HOLDOFF;
                end
                HOLDOFF: begin
                    if (holdCnt == 4'(HOLDOFF_CYCLES - 1)) state <= IDLE;
                    else                                  holdCnt <= holdCnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign coinBus.fiveKurus       = coinPulse[0];
    assign coinBus.tenKurus        = coinPulse[1];
    assign coinBus.twentyFiveKurus = coinPulse[2];
    assign coinBus.coinReject      = rejectQ;

`ifdef COIN_TOTAL_EN
    logic [7:0] total;
    logic [8:0] addend;
    logic [8:0] sum;

    always_comb begin
        addend = 9'd0;
        case (coinPulse)
            3'b001:  addend = 9'd5;
            3'b010:  addend = 9'd10;
            3'b100:  addend = 9'd25;
            default: addend = 9'd0;
        endcase
    end

    assign sum = {1'b0, total} + addend;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            total <= '0;
        end else if (coinBus.clearTotal) begin
            total <= '0;
        end else if (coinPulse != 3'b000) begin
            total <= sum[8] ? 8'd255 : sum[7:0];
        end
    end

    assign coinBus.totalKurus = total;
`endif
endmodule
